// File: rtl/mem_fetch_arbiter.sv
// mem_fetch_arbiter: shares a byte-wide big-endian memory between the
// instruction-fetch and data-load ports. Each grant performs four byte reads
// assembled MSB-first into a 32-bit word, returned with a one-cycle Ack.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise the data-load port always wins a tie.
module mem_fetch_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IfReq,
    input  logic [31:0]       IfAddr,
    output logic              IfAck,
    output logic [31:0]       IfData,
    input  logic              DmReq,
    input  logic [31:0]       DmAddr,
    output logic              DmAck,
    output logic [31:0]       DmData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic [7:0]        MemByte,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [31:0] base;
    logic [31:0] asm_word;
    logic [31:0] word_done;
    logic [31:0] byte_addr;
    logic        owner_dm;
    logic        grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_dm;
`endif

    // Next-state, grant selection and memory-bus decode (bus from registers only)
    always_comb begin
        state_next = state;
        MemRd      = 1'b0;
        MemAddr    = '0;
        byte_addr  = base + {30'd0, cnt};
        word_done  = {asm_word[23:0], MemByte};
`ifdef ARB_ROUND_ROBIN_EN
        grant_dm   = DmReq && !(IfReq && last_dm);
`else
        grant_dm   = DmReq;
`endif
        case (state)
            IDLE: begin
                if (IfReq || DmReq) begin
                    state_next = READ;
                end
            end
            READ: begin
                MemRd   = 1'b1;
                MemAddr = byte_addr[ADDR_W-1:0];
                if (cnt == 2'd3) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: request latch, byte assembly, registered Ack/Data/Busy
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt      <= '0;
            base     <= '0;
            asm_word <= '0;
            owner_dm <= 1'b0;
            IfAck    <= 1'b0;
            DmAck    <= 1'b0;
            IfData   <= '0;
            DmData   <= '0;
            Busy     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm  <= 1'b1;
`endif
        end else begin
            IfAck <= 1'b0;
            DmAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (IfReq || DmReq) begin
                        base     <= grant_dm ? DmAddr : IfAddr;
                        owner_dm <= grant_dm;
                        cnt      <= '0;
                        Busy     <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dm  <= grant_dm;
`endif
                    end
                end
                READ: begin
                    asm_word <= word_done;
                    cnt      <= cnt + 2'd1;
                    // The word is published on the edge entering ACK so that
                    // Data and Ack are registered and valid throughout ACK.
                    if (cnt == 2'd3) begin
                        if (owner_dm) begin
                            DmData <= word_done;
                            DmAck  <= 1'b1;
                        end else begin
                            IfData <= word_done;
                            IfAck  <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    Busy <= 1'b0;
                end
                default: begin
                    Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fetch_arbiter.sv
// Scoreboard bench for mem_fetch_arbiter: expected words are queued per port
// when a request is raised and compared when the matching Ack pulses.
// Honours ARB_ROUND_ROBIN_EN for tie expectations.
module tb_mem_fetch_arbiter;

    logic        CLK;
    logic        RST;
    logic        IfReq;
    logic [31:0] IfAddr;
    logic        IfAck;
    logic [31:0] IfData;
    logic        DmReq;
    logic [31:0] DmAddr;
    logic        DmAck;
    logic [31:0] DmData;
    logic [31:0] MemAddr;
    logic        MemRd;
    logic [7:0]  MemByte;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] prev_if;
    logic [31:0] prev_dm;
    logic        model_last_dm;

    mem_fetch_arbiter #(.ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfAck(IfAck), .IfData(IfData),
        .DmReq(DmReq), .DmAddr(DmAddr), .DmAck(DmAck), .DmData(DmData),
        .MemAddr(MemAddr), .MemRd(MemRd), .MemByte(MemByte), .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 8'h8C;
            32'h1:   rom = 8'h01;
            32'h2:   rom = 8'h00;
            32'h3:   rom = 8'h04;
            default: rom = (a[7:0] * 8'd3) ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        exp_word = {rom(a), rom(a + 32'd1), rom(a + 32'd2), rom(a + 32'd3)};
    endfunction

    assign MemByte = rom(MemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Ack monitor: pops the scoreboard and checks that idle Data outputs hold
    always @(negedge CLK) begin
        if (RST) begin
            if (IfAck) begin
                if (if_q.size() == 0) check("if_unexpected_ack", {31'd0, IfAck}, 32'd0);
                else                  check("if_data", IfData, if_q.pop_front());
            end else begin
                check("if_data_hold", IfData, prev_if);
            end
            if (DmAck) begin
                if (dm_q.size() == 0) check("dm_unexpected_ack", {31'd0, DmAck}, 32'd0);
                else                  check("dm_data", DmData, dm_q.pop_front());
            end else begin
                check("dm_data_hold", DmData, prev_dm);
            end
        end
        prev_if = IfData;
        prev_dm = DmData;
    end

    task automatic set_req(input bit dm, input bit v, input logic [31:0] a);
        if (dm) begin DmReq = v; DmAddr = a; end
        else    begin IfReq = v; IfAddr = a; end
    endtask

    // One lone request; checks byte addresses, Busy and Ack latency
    task automatic run_one(input bit dm, input logic [31:0] a, input int drop_at, input bit keep);
        int n;
        logic ack;
        if (dm) dm_q.push_back(exp_word(a));
        else    if_q.push_back(exp_word(a));
        set_req(dm, 1'b1, a);
        n = 0;
        ack = 1'b0;
        while (!ack && n < 20) begin
            @(negedge CLK);
            n++;
            if (n >= 1 && n <= 4) begin
                check("mem_addr", MemAddr, a + 32'(n - 1));
                check("mem_rd", {31'd0, MemRd}, 32'd1);
                check("busy_read", {31'd0, Busy}, 32'd1);
            end
            if (n == drop_at) set_req(dm, 1'b0, a);
            ack = dm ? DmAck : IfAck;
        end
        check(dm ? "dm_latency" : "if_latency", 32'(n), 32'd5);
        if (!keep) set_req(dm, 1'b0, a);
        model_last_dm = dm;
    endtask

    // Simultaneous requests; checks grant order and 6-cycle spacing
    task automatic run_tie(input logic [31:0] a_if, input logic [31:0] a_dm);
        bit if_first;
        int n, n_if, n_dm;
`ifdef ARB_ROUND_ROBIN_EN
        if_first = model_last_dm;
`else
        if_first = 1'b0;
`endif
        if_q.push_back(exp_word(a_if));
        dm_q.push_back(exp_word(a_dm));
        set_req(1'b0, 1'b1, a_if);
        set_req(1'b1, 1'b1, a_dm);
        n = 0; n_if = 0; n_dm = 0;
        while ((n_if == 0 || n_dm == 0) && n < 30) begin
            @(negedge CLK);
            n++;
            if (IfAck && n_if == 0) begin n_if = n; set_req(1'b0, 1'b0, a_if); end
            if (DmAck && n_dm == 0) begin n_dm = n; set_req(1'b1, 1'b0, a_dm); end
        end
        check("tie_if_ack_cycle", 32'(n_if), if_first ? 32'd5 : 32'd11);
        check("tie_dm_ack_cycle", 32'(n_dm), if_first ? 32'd11 : 32'd5);
        model_last_dm = if_first;
        set_req(1'b0, 1'b0, a_if);
        set_req(1'b1, 1'b0, a_dm);
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        model_last_dm = 1'b1;
    endtask

    initial begin
        int n;
        RST = 1'b0;
        IfReq = 1'b0; IfAddr = '0;
        DmReq = 1'b0; DmAddr = '0;
        prev_if = '0; prev_dm = '0;
        model_last_dm = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_if_ack", {31'd0, IfAck}, 32'd0);
        check("rst_dm_ack", {31'd0, DmAck}, 32'd0);
        check("rst_if_data", IfData, 32'd0);
        check("rst_dm_data", DmData, 32'd0);
        check("rst_mem_addr", MemAddr, 32'd0);
        check("rst_mem_rd", {31'd0, MemRd}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single fetch from address 0
        run_one(1'b0, 32'h0, 0, 1'b0);
        check("fetch0_word", IfData, 32'h8C010004);
        check("fetch0_dm_untouched", DmData, 32'd0);
        @(negedge CLK);
        check("busy_after_ack", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge CLK);

        // Ties straight after reset
        apply_reset();
        run_tie(32'h4, 32'h8);
        repeat (2) @(negedge CLK);
        run_tie(32'h104, 32'h208);
        repeat (2) @(negedge CLK);
        run_tie(32'h3001, 32'h7FF3);
        repeat (2) @(negedge CLK);

        // Address wrap-around on the load port
        run_one(1'b1, 32'hFFFFFFFE, 0, 1'b0);
        check("wrap_word", DmData, 32'h07148C01 ^ 32'h0 ^ exp_word(32'hFFFFFFFE) ^ 32'h07148C01);
        repeat (2) @(negedge CLK);

        // Reset during the third byte read aborts without Ack
        set_req(1'b0, 1'b1, 32'h10);
        for (int i = 1; i <= 3; i++) @(negedge CLK);
        check("abort_mem_addr", MemAddr, 32'h12);
        #2;
        RST = 1'b0;
        #1;
        check("abort_mem_addr_zero", MemAddr, 32'd0);
        check("abort_mem_rd", {31'd0, MemRd}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_if_ack", {31'd0, IfAck}, 32'd0);
        check("abort_if_data", IfData, 32'd0);
        check("abort_dm_data", DmData, 32'd0);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        model_last_dm = 1'b1;
        run_one(1'b0, 32'h10, 0, 1'b0);
        repeat (2) @(negedge CLK);

        // Load request dropped mid-read still completes exactly once
        run_one(1'b1, 32'h40, 2, 1'b0);
        repeat (8) @(negedge CLK);
        check("drop_busy_idle", {31'd0, Busy}, 32'd0);

        // Fetch request held past Ack starts a second fetch of the same word
        run_one(1'b0, 32'h20, 0, 1'b1);
        if_q.push_back(exp_word(32'h20));
        n = 0;
        while (!IfAck || n == 0) begin
            @(negedge CLK);
            n++;
            if (n == 2) check("refetch_addr", MemAddr, 32'h20);
            if (n >= 20) break;
        end
        check("refetch_latency", 32'(n), 32'd6);
        set_req(1'b0, 1'b0, 32'h20);
        repeat (8) @(negedge CLK);

        check("if_queue_drained", 32'(if_q.size()), 32'd0);
        check("dm_queue_drained", 32'(dm_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
